// File: rtl/imem_loader_if.sv
// Byte-stream in / instruction-memory write port out, as seen by the loader.
// master: loader side; slave: byte source and memory side (testbench or SoC glue).
interface imem_loader_if #(
    parameter int ADDR_W = 16
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: parses A5/count/words[/checksum] frames from a byte
// stream, writes words into instruction memory and holds the core until done.
// Ports: CLK, RST (sync, active-high); bus (imem_loader_if.master: rx_valid,
// rx_data, rx_ready, imem_we, imem_addr, imem_wdata); core_hold, done, err.
// Option: define LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte.
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    imem_loader_if.master bus,
    output logic         core_hold,
    output logic         done,
    output logic         err
);
    typedef enum logic [3:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DAT_HI,
        S_DAT_LO,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    // State entered once the last word (or a zero count) has been handled.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t L_FIN = S_CHK;
`else
    localparam state_t L_FIN = S_DONE;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_cnt;
    logic [7:0]        r_hi;
    logic [7:0]        r_lo;
    logic [ADDR_W-1:0] r_idx;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_sum;
`endif

    logic        w_acc;
    logic        w_hdr;
    logic [15:0] w_cnt;
    logic        w_last;

    assign w_acc  = bus.rx_valid && bus.rx_ready;
    assign w_hdr  = w_acc && (bus.rx_data == 8'hA5);
    assign w_cnt  = {r_cnt[15:8], bus.rx_data};
    assign w_last = (32'(r_idx) + 32'd1) == {16'd0, r_cnt};

    assign bus.rx_ready   = (r_state != S_WRITE);
    assign bus.imem_we    = (r_state == S_WRITE);
    assign bus.imem_addr  = r_idx;
    assign bus.imem_wdata = {r_hi, r_lo};
    assign core_hold      = (r_state != S_DONE);
    assign done           = (r_state == S_DONE);
    assign err            = (r_state == S_ERR);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_hdr) w_state_nxt = S_CNT_HI;
            end
            S_CNT_HI: begin
                if (w_acc) w_state_nxt = S_CNT_LO;
            end
            S_CNT_LO: begin
                if (w_acc) begin
                    if ({16'd0, w_cnt} > 32'(DEPTH))
                        w_state_nxt = S_ERR;
                    else if (w_cnt == 16'd0)
                        w_state_nxt = L_FIN;
                    else
                        w_state_nxt = S_DAT_HI;
                end
            end
            S_DAT_HI: begin
                if (w_acc) w_state_nxt = S_DAT_LO;
            end
            S_DAT_LO: begin
                if (w_acc) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                w_state_nxt = w_last ? L_FIN : S_DAT_HI;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_acc)
                    w_state_nxt = (bus.rx_data == r_sum) ? S_DONE : S_ERR;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_WRITE) r_idx <= r_idx + 1'b1;
            if (w_acc) begin
                unique case (r_state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (w_hdr) begin
                            r_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                            r_sum <= '0;
`endif
                        end
                    end
                    S_CNT_HI: r_cnt[15:8] <= bus.rx_data;
                    S_CNT_LO: r_cnt[7:0]  <= bus.rx_data;
                    S_DAT_HI: r_hi        <= bus.rx_data;
                    S_DAT_LO: r_lo        <= bus.rx_data;
                    default: ;
                endcase
`ifdef LOADER_CHECKSUM_EN
                // Every byte after the header up to the checksum itself.
                if (r_state inside {S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO})
                    r_sum <= r_sum + bus.rx_data;
`endif
            end
        end
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes a program image into the instruction memory the pipelined 16-bit core fetches from. It sits outside the core, between a byte-stream source (UART receiver or testbench) and the instruction memory write port. It holds the core stalled until a complete, length-checked image has been written. This block is the writer side of the instruction-memory interface; the datapath is the reader.

## Interface
- DEPTH, 256: instruction memory size in 16-bit words; images with more words are rejected.
- ADDR_W, 16: instruction address width, matching PC width.
- CLK  in  1  rising-edge clock, same clock as the core.
- RST  in  1  synchronous, active-high reset.
- rx_valid  in  1  byte on rx_data is valid.
- rx_data  in  8  incoming byte.
- rx_ready  out  1  loader accepts the byte; transfer occurs on a CLK edge with rx_valid && rx_ready.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  16  instruction word.
- core_hold  out  1  stall/hold request to the core; 1 = core must not fetch.
- done  out  1  image loaded successfully (level).
- err  out  1  image rejected (level).

## Operation
- Frame format: header 0xA5, count_hi, count_lo, then count words each sent high byte first, then the checksum byte (only with LOADER_CHECKSUM_EN).
- FSM states: IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, CHK, DONE, ERR.
- IDLE: accept and discard bytes until 0xA5 is received -> CNT_HI. On the header, clear done and err, set core_hold=1, address=0, sum=0.
- CNT_HI / CNT_LO: latch the 16-bit count, big-endian.
  - After CNT_LO: count > DEPTH -> ERR.
  - count == 0 -> CHK (checksum on) or DONE (checksum off).
  - Otherwise -> DAT_HI.
- DAT_HI latches the high byte; DAT_LO latches the low byte -> WRITE.
- WRITE: exactly one cycle.
  - imem_we=1, imem_wdata={hi,lo}, imem_addr=current word index; rx_ready=0.
  - Word index increments after the write.
  - If the word just written was the last one -> CHK/DONE; else -> DAT_HI.
- CHK: the received byte must equal the 8-bit sum (mod 256) of every byte after the header (count bytes and data bytes). Equal -> DONE, else -> ERR.
- DONE: done=1, core_hold=0.
- ERR: err=1, core_hold=1.
- DONE and ERR are sticky. Bytes other than 0xA5 are discarded; a 0xA5 header restarts the load as in IDLE.
- A second 0xA5 received mid-frame is treated as data, not as a restart.
- Word index is ADDR_W bits and never wraps, because count ≤ DEPTH is enforced.

## Timing
- Reset values: state=IDLE, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, done=0, err=0.
- rx_ready=1 in every state except WRITE.
- Each data word costs three cycles minimum: DAT_HI, DAT_LO, WRITE. rx_valid may stay high across WRITE; the byte is simply not consumed.
- imem_we asserts the cycle after the edge that accepted the low byte. imem_addr and imem_wdata are stable while imem_we=1.
- done/err and core_hold update on the edge after the final byte (checksum, or last WRITE cycle).
- RST mid-frame: return to IDLE next edge with reset values. No further writes; memory contents already written are left as-is.
- RST and rx_valid asserted in the same cycle: RST wins and the byte is dropped.

## Configuration
- LOADER_CHECKSUM_EN defined: CHK state present; the frame ends with the checksum byte; a mismatch gives err.
- LOADER_CHECKSUM_EN undefined: no CHK state and no sum register. The frame ends after the last WRITE (or after CNT_LO when count=0) -> DONE. err occurs only for count > DEPTH.

## Test plan
- Checksum on; send A5 00 02 12 34 AB CD C0 -> writes (0,0x1234) then (1,0xABCD), one imem_we pulse each. done=1, core_hold=0, err=0.
- Same frame with checksum byte C1 -> both writes occur; err=1, done=0, core_hold=1.
- Send 00 FF A5 00 00 C0 (checksum off: A5 00 00 only) -> leading bytes ignored. Checksum on: checksum 00 is expected, so C0 gives err=1. Checksum off: done=1 with no imem_we.
- DEPTH=256; send A5 01 01 -> err=1 after the count_lo edge; no imem_we ever.
- Assert RST after A5 00 02 12 -> no write occurs; outputs return to reset values; a subsequent full valid frame gives done=1.
- Hold rx_valid=1 continuously with back-to-back bytes -> rx_ready=0 exactly in the WRITE cycles. No byte is lost or duplicated; written data matches.
